// File: rtl/imem_loadable.sv
// Loadable instruction memory: registered fetch port with fault flags, streaming
// program-load port, RUN/LOAD controller. Optional parity via IMEM_PARITY_EN.
module imem_loadable #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 1024,
  localparam int IDX_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              fetch_req,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic              fetch_valid,
  output logic [DATA_W-1:0] fetch_instr,
  output logic              fetch_misaligned,
  output logic              fetch_oob,
  output logic              fetch_parity_err,
  input  logic              load_start,
  input  logic              load_valid,
  input  logic [DATA_W-1:0] load_data,
  input  logic              load_last,
  output logic              load_ready,
  output logic              load_done,
  output logic              busy
);

  // Handshake: a load word transfers on any edge where load_valid && load_ready;
  // load_ready is high exactly while the controller is in LOAD.

  typedef enum logic {RUN = 1'b0, LOAD = 1'b1} state_t;

  localparam logic [ADDR_W-2:0] DEPTH_CMP = (ADDR_W-1)'(DEPTH);
  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(DEPTH - 1);

  state_t            state;
  logic [IDX_W-1:0]  ptr;
  logic [DATA_W-1:0] mem [DEPTH];

  logic [ADDR_W-3:0] word_idx;
  logic [IDX_W-1:0]  mem_idx;
  logic              addr_oob;
  logic              load_we;
  logic              par_mismatch;

  assign word_idx = fetch_addr[ADDR_W-1:2];
  assign mem_idx  = word_idx[IDX_W-1:0];
  assign addr_oob = {1'b0, word_idx} >= DEPTH_CMP;
  assign load_we  = (state == LOAD) && load_valid;

  // Memory array is never reset; contents survive a reset mid-load.
  always_ff @(posedge clk) begin
    if (load_we) mem[ptr] <= load_data;
  end

`ifdef IMEM_PARITY_EN
  logic par_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (load_we) par_mem[ptr] <= ^load_data;
  end

  assign par_mismatch = (^mem[mem_idx]) != par_mem[mem_idx];
`else
  assign par_mismatch = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state            <= RUN;
      ptr              <= '0;
      fetch_valid      <= 1'b0;
      fetch_instr      <= '0;
      fetch_misaligned <= 1'b0;
      fetch_oob        <= 1'b0;
      fetch_parity_err <= 1'b0;
      load_ready       <= 1'b0;
      load_done        <= 1'b0;
      busy             <= 1'b0;
    end else begin
      load_done <= 1'b0;
      case (state)
        RUN: begin
          fetch_valid      <= fetch_req;
          fetch_misaligned <= fetch_req && (fetch_addr[1:0] != 2'b00);
          fetch_oob        <= fetch_req && addr_oob;
          fetch_parity_err <= fetch_req && !addr_oob && par_mismatch;
          if (fetch_req) fetch_instr <= addr_oob ? '0 : mem[mem_idx];
          // A fetch issued alongside load_start is still serviced from old contents.
          if (load_start) begin
            state      <= LOAD;
            ptr        <= '0;
            busy       <= 1'b1;
            load_ready <= 1'b1;
          end
        end
        LOAD: begin
          fetch_valid      <= 1'b0;
          fetch_misaligned <= 1'b0;
          fetch_oob        <= 1'b0;
          fetch_parity_err <= 1'b0;
          if (load_valid) begin
            if (load_last || ptr == LAST_IDX) begin
              state      <= RUN;
              busy       <= 1'b0;
              load_ready <= 1'b0;
              load_done  <= 1'b1;
            end
            // Pointer saturates at the last word instead of wrapping.
            if (ptr != LAST_IDX) ptr <= ptr + 1'b1;
          end
        end
        default: state <= RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loadable.sv
// Randomised scoreboard bench for imem_loadable: a word-array model predicts
// each fetch response and the busy/load_done timeline.
module tb_imem_loadable;

  localparam int ADDR_W = 16;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 1024;
  localparam int EW     = 66;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              fetch_req = 1'b0;
  logic [ADDR_W-1:0] fetch_addr = '0;
  logic              fetch_valid;
  logic [DATA_W-1:0] fetch_instr;
  logic              fetch_misaligned;
  logic              fetch_oob;
  logic              fetch_parity_err;
  logic              load_start = 1'b0;
  logic              load_valid = 1'b0;
  logic [DATA_W-1:0] load_data = '0;
  logic              load_last = 1'b0;
  logic              load_ready;
  logic              load_done;
  logic              busy;

  imem_loadable #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr),
    .fetch_valid(fetch_valid), .fetch_instr(fetch_instr),
    .fetch_misaligned(fetch_misaligned), .fetch_oob(fetch_oob),
    .fetch_parity_err(fetch_parity_err),
    .load_start(load_start), .load_valid(load_valid), .load_data(load_data),
    .load_last(load_last), .load_ready(load_ready), .load_done(load_done),
    .busy(busy)
  );

  // clock / reset
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  // reference model and scoreboard state
  logic [DATA_W-1:0] m_mem [DEPTH];
  logic              m_loading = 1'b0;
  int                m_ptr = 0;
  logic              exp_busy = 1'b0;
  logic              exp_done = 1'b0;
  logic [DATA_W-1:0] exp_hold = '0;
  logic [EW-1:0]     exp_q[$];
  logic              mon_en = 1'b0;
  logic [EW-1:0]     mon_e;
  int                total = 0;
  int                bad = 0;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at cycle %0d: actual=%0h required=%0h", name, cyc, act, exp);
    end
  endfunction

  // driver tasks
  task automatic cycle(input logic fr, input logic [ADDR_W-1:0] fa, input logic ls,
                       input logic lv, input logic [DATA_W-1:0] ld, input logic ll);
    int idx;
    logic [DATA_W-1:0] w;
    logic fetched;
    logic done;
    fetch_req = fr; fetch_addr = fa; load_start = ls;
    load_valid = lv; load_data = ld; load_last = ll;
    fetched = 1'b0; done = 1'b0; w = '0;
    if (!m_loading) begin
      if (fr) begin
        idx = int'(fa >> 2);
        if (idx < DEPTH) w = m_mem[idx];
        exp_q.push_back({cyc + 1, w, fa[1:0] != 2'b00, idx >= DEPTH});
        fetched = 1'b1;
      end
      if (ls) begin
        m_loading = 1'b1;
        m_ptr = 0;
      end
    end else if (lv) begin
      m_mem[m_ptr] = ld;
      if (ll || m_ptr == DEPTH - 1) begin
        m_loading = 1'b0;
        done = 1'b1;
      end else begin
        m_ptr++;
      end
    end
    @(posedge clk);
    exp_busy = m_loading;
    exp_done = done;
    if (fetched) exp_hold = w;
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) cycle(1'b0, '0, 1'b0, 1'b0, '0, 1'b0);
  endtask

  task automatic fetch(input logic [ADDR_W-1:0] fa);
    cycle(1'b1, fa, 1'b0, 1'b0, '0, 1'b0);
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1; fetch_req = 1'b0; load_start = 1'b0; load_valid = 1'b0; load_last = 1'b0;
    m_loading = 1'b0;
    repeat (n) begin
      @(posedge clk);
      exp_busy = 1'b0;
      exp_done = 1'b0;
      exp_hold = '0;
      #1;
    end
    reset = 1'b0;
  endtask

  function automatic logic [ADDR_W-1:0] rand_addr();
    case ($urandom_range(0, 3))
      0: return ADDR_W'($urandom_range(0, 15) << 2);
      1: return ADDR_W'($urandom_range(0, 65535));
      2: return ADDR_W'($urandom_range(16'h0FF0, 16'h100F));
      default: return ADDR_W'($urandom_range(0, 63));
    endcase
  endfunction

  // monitor: pops one expected response per fetch_valid, checks control timeline
  always @(negedge clk) begin
    if (mon_en) begin
      while (exp_q.size() > 0 && int'(exp_q[0][65:34]) < cyc) begin
        mon_e = exp_q.pop_front();
        total++; bad++;
        $display("FAIL missing_valid at cycle %0d: actual=no response required=response due cycle %0d",
                 cyc, mon_e[65:34]);
      end
      if (fetch_valid) begin
        if (exp_q.size() == 0) begin
          total++; bad++;
          $display("FAIL spurious_valid at cycle %0d: actual=fetch_valid 1 required=0", cyc);
        end else begin
          mon_e = exp_q.pop_front();
          chk("due_cycle", 64'(cyc), 64'(mon_e[65:34]));
          chk("instr", 64'(fetch_instr), 64'(mon_e[33:2]));
          chk("misaligned", 64'(fetch_misaligned), 64'(mon_e[1]));
          chk("oob", 64'(fetch_oob), 64'(mon_e[0]));
          chk("parity_err", 64'(fetch_parity_err), 64'd0);
        end
      end else begin
        chk("flags_idle", 64'({fetch_misaligned, fetch_oob, fetch_parity_err}), 64'd0);
        chk("instr_hold", 64'(fetch_instr), 64'(exp_hold));
      end
      chk("busy", 64'(busy), 64'(exp_busy));
      chk("load_ready", 64'(load_ready), 64'(exp_busy));
      chk("load_done", 64'(load_done), 64'(exp_done));
    end
  end

  initial begin
    for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;

    // reset state
    do_reset(2);
    chk("rst_fetch_valid", 64'(fetch_valid), 64'd0);
    chk("rst_fetch_instr", 64'(fetch_instr), 64'd0);
    chk("rst_flags", 64'({fetch_misaligned, fetch_oob, fetch_parity_err}), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_load_ready", 64'(load_ready), 64'd0);
    chk("rst_load_done", 64'(load_done), 64'd0);
    mon_en = 1'b1;

    // back-to-back fetches of power-up contents
    fetch(16'h0000); fetch(16'h0004); fetch(16'h0008); idle(1);

    // three-word load terminated by load_last, then read back
    cycle(1'b0, '0, 1'b1, 1'b0, '0, 1'b0);
    cycle(1'b0, '0, 1'b0, 1'b1, 32'h0000_0020, 1'b0);
    cycle(1'b0, '0, 1'b0, 1'b1, 32'h0000_0021, 1'b0);
    cycle(1'b0, '0, 1'b0, 1'b1, 32'h0000_0031, 1'b1);
    idle(1);
    fetch(16'h0000); fetch(16'h0004); fetch(16'h0008); fetch(16'h000C);

    // misaligned and out-of-range fetches
    fetch(16'h0002); fetch(16'h1000); fetch(16'hFFFF); fetch(16'h0FFC); idle(1);

    // fetch_req held through a two-word load, including the load_start cycle
    cycle(1'b1, 16'h0004, 1'b1, 1'b0, '0, 1'b0);
    cycle(1'b1, 16'h0004, 1'b0, 1'b1, 32'hDEAD_0001, 1'b0);
    cycle(1'b1, 16'h0004, 1'b1, 1'b0, '0, 1'b0);
    cycle(1'b1, 16'h0004, 1'b0, 1'b1, 32'hDEAD_0002, 1'b1);
    cycle(1'b1, 16'h0000, 1'b0, 1'b0, '0, 1'b0);
    cycle(1'b1, 16'h0004, 1'b0, 1'b0, '0, 1'b0);
    idle(1);

    // full-depth load with no load_last: auto-completes on the final word
    cycle(1'b0, '0, 1'b1, 1'b0, '0, 1'b0);
    while (m_loading)
      cycle(1'($urandom_range(0, 1)), rand_addr(), 1'($urandom_range(0, 7) == 0),
            1'($urandom_range(0, 3) != 0), $urandom, 1'b0);
    fetch(16'h0FFC); fetch(16'h0000); fetch(16'h0800);
    repeat (40) fetch(rand_addr());
    idle(1);

    // reset after two of four load words
    cycle(1'b0, '0, 1'b1, 1'b0, '0, 1'b0);
    for (int i = 0; i < 4; i++) cycle(1'b0, '0, 1'b0, 1'b1, 32'hA000_0000 + i, i == 3);
    cycle(1'b0, '0, 1'b1, 1'b0, '0, 1'b0);
    cycle(1'b0, '0, 1'b0, 1'b1, 32'hB000_0000, 1'b0);
    cycle(1'b0, '0, 1'b0, 1'b1, 32'hB000_0001, 1'b0);
    do_reset(1);
    fetch(16'h0000); fetch(16'h0004); fetch(16'h0008); fetch(16'h000C); idle(1);

    // random mixed traffic
    repeat (600)
      cycle(1'($urandom_range(0, 1)), rand_addr(), 1'($urandom_range(0, 24) == 0),
            1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 3) == 0));
    while (m_loading) cycle(1'b0, '0, 1'b0, 1'b1, $urandom, 1'b1);
    idle(2);

    chk("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/imem_loadable.md
Name: imem_loadable

Overview:
- Parametrised instruction memory for the single-cycle CPU, replacing the fixed, combinational, initial-block-filled ROM.
- Adds three things the ROM lacks:
  - a registered fetch port with valid signalling and alignment/range fault flags;
  - a streaming program-load port that rewrites memory at run time;
  - a two-state controller that stalls fetch while a load is in progress.
- Sits between the PC register and the decoder.

Parameters:
- ADDR_W, 16, byte-address width of fetch_addr.
- DATA_W, 32, instruction word width.
- DEPTH, 1024, number of words. Must be ≤ 2^(ADDR_W-2).
- IDX_W, $clog2(DEPTH), word-index width. Derived, not overridable.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- fetch_req  in  1  fetch request, sampled each clk.
- fetch_addr  in  ADDR_W  byte address (PC).
- fetch_valid  out  1  fetch_instr valid this cycle.
- fetch_instr  out  DATA_W  fetched word.
- fetch_misaligned  out  1  fetch_addr[1:0] != 0 for the returned fetch.
- fetch_oob  out  1  word index >= DEPTH for the returned fetch.
- fetch_parity_err  out  1  parity mismatch on the returned fetch (see Optional Feature).
- load_start  in  1  begin program load at word 0.
- load_valid  in  1  load_data valid.
- load_data  in  DATA_W  word to write.
- load_last  in  1  marks final load word, qualified by load_valid.
- load_ready  out  1  block accepts a load word.
- load_done  out  1  one-cycle pulse at load completion.
- busy  out  1  high while in LOAD.

Behaviour:
- Single clock domain (clk). Synchronous, active-high reset. Nothing is asynchronous.
- Reset values:
  - state = RUN.
  - fetch_valid, fetch_instr, fetch_misaligned, fetch_oob, fetch_parity_err, load_done, busy = 0.
  - Write pointer = 0.
  - load_ready = 0.
  - Memory contents are NOT cleared by reset; power-up contents are all zero.
- Word index = fetch_addr[ADDR_W-1:2]. Bits [1:0] are ignored for addressing.
- State RUN:
  - fetch_req=1 at edge N: at edge N+1, fetch_valid=1 and fetch_instr = mem[index]. Latency is exactly 1 cycle; one fetch per cycle, back-to-back fetches supported.
  - fetch_req=0 at edge N: fetch_valid=0 after edge N+1. fetch_instr holds its last value.
  - Misaligned fetch: fetch_valid=1, fetch_misaligned=1, fetch_instr = mem[index] (truncated index).
  - Out-of-range fetch (index >= DEPTH): fetch_valid=1, fetch_oob=1, fetch_instr = 0. No array access.
  - Fault flags are qualified by fetch_valid and are 0 whenever fetch_valid=0.
  - load_start=1: next state = LOAD, pointer = 0.
  - load_start together with fetch_req in the same cycle: the fetch is still serviced (returns pre-load contents), and LOAD is entered next.
- State LOAD:
  - busy=1 and load_ready=1.
  - fetch_req is ignored; fetch_valid=0.
  - load_valid=1 at an edge: mem[ptr] <= load_data, then ptr increments.
  - Completion condition: load_last=1 with load_valid=1, or a write to word DEPTH-1.
  - On completion: return to RUN next cycle and pulse load_done=1 for exactly one cycle coincident with busy falling. The pointer does not wrap.
  - load_start asserted while already in LOAD is ignored.
  - load_valid while in RUN is ignored; no write occurs.
- Reset mid-load:
  - Return to RUN immediately; load_done is not pulsed.
  - Words already written are retained.
- Read-during-write cannot occur, because fetch and load are mutually exclusive by state.

Optional Feature:
- Macro: IMEM_PARITY_EN.
- Defined:
  - Each word stores an extra even-parity bit computed from load_data at write time.
  - On every valid in-range fetch, parity is recomputed. fetch_parity_err=1 with fetch_valid if the stored and recomputed parity disagree.
  - Power-up parity bits are 0, which is consistent with all-zero data.
- Not defined:
  - No parity storage.
  - fetch_parity_err is tied to 0; the port is always present.

Test Plan:
- Reset, then fetch addresses 0x0000, 0x0004, 0x0008 on consecutive cycles → fetch_valid high on the three following cycles; fetch_instr = 0x00000000 each time; all flags 0.
- load_start, then stream 0x00000020, 0x00000021, 0x00000031 with load_last on the third word → busy high for 3 cycles; load_done pulses once; subsequent fetches of 0x0/0x4/0x8 return the three words; fetch of 0xC returns 0.
- Issue fetch_req at 0x0002 → fetch_valid=1, fetch_misaligned=1, fetch_instr = word 0. Issue fetch at 0x1000 with DEPTH=1024 → fetch_oob=1, fetch_instr=0.
- fetch_req held high during an entire load of 2 words → fetch_valid stays 0 while busy; fetching resumes the cycle after load_done.
- Stream DEPTH words with no load_last → auto-completion after word 1023; load_done pulses; word 1023 reads back correctly.
- Assert reset after 2 of 4 load words → busy=0 and no load_done; words 0-1 hold new values; words 2-3 hold old values.
